// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, serializer states and the STATUS word builder.
package mmio_uart_tx_pkg;

   localparam logic [1:0] UART_REG_TXDATA = 2'd0;
   localparam logic [1:0] UART_REG_STATUS = 2'd1;
   localparam logic [1:0] UART_REG_DIV    = 2'd2;

   localparam int unsigned UART_ST_FULL  = 0;
   localparam int unsigned UART_ST_EMPTY = 1;
   localparam int unsigned UART_ST_BUSY  = 2;
   localparam int unsigned UART_ST_OVF   = 3;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   function automatic logic [31:0] uart_status_word(input logic       full,
                                                    input logic       empty,
                                                    input logic       busy,
                                                    input logic       ovf,
                                                    input logic [7:0] cnt);
      logic [31:0] w;
      w                = '0;
      w[UART_ST_FULL]  = full;
      w[UART_ST_EMPTY] = empty;
      w[UART_ST_BUSY]  = busy;
      w[UART_ST_OVF]   = ovf;
      w[15:8]          = cnt;
      return w;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmit path; pointers carry an
// extra MSB so full and empty are distinguished without a separate flag.
module uart_tx_fifo
   import mmio_uart_tx_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push, do_pop;

   assign count = wptr_q - rptr_q;
   assign full  = (count == (AW + 1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem_q[rptr_q[AW-1:0]];

   // A pop in the same cycle frees a slot, so a push to a full FIFO is accepted then.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the CPU data-RAM port: 4-word register
// window, TX FIFO and an 8N1 serializer with a per-frame latched divisor.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [29:0] BASE_WADDR = 30'h0000_4000,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] address,
   input  logic [3:0]  byteena,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q,
   output logic        sel,
   output logic        tx,
   output logic        irq_empty
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [29:0]   off;
   logic          in_win;
   logic [1:0]    reg_idx;
   logic          wr_txdata, wr_status, wr_div;
   logic          clr_ovf, push_drop;

   logic [7:0]    f_dout;
   logic          f_full, f_empty, f_pop;
   logic [CW-1:0] f_count;
   logic [8:0]    cnt9;

   uart_state_e   state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   div_lat_q, div_lat_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic [15:0]   div_q, div_d;
   logic [15:0]   div_eff;
   logic          ovf_q, ovf_d;
   logic [31:0]   q_q, q_d;
   logic          sel_q, sel_d;
   logic          unused_bits;

   // Subtracting the base makes addresses below the window wrap high and fall out.
   assign off     = address - BASE_WADDR;
   assign in_win  = (off < 30'd4);
   assign reg_idx = off[1:0];

   assign wr_txdata = wren & in_win & (reg_idx == UART_REG_TXDATA) & byteena[0];
   assign wr_status = wren & in_win & (reg_idx == UART_REG_STATUS);
   assign wr_div    = wren & in_win & (reg_idx == UART_REG_DIV);
   assign clr_ovf   = wr_status & byteena[0] & data[UART_ST_OVF];
   assign push_drop = wr_txdata & f_full & ~f_pop;

   assign div_eff = (div_q == '0) ? 16'd1 : div_q;
   assign cnt9    = 9'(f_count);

   assign unused_bits = ^{data[31:16], byteena[3:2], cnt9[8]};

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .din   (data[7:0]),
      .pop   (f_pop),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      cnt_d     = cnt_q;
      div_lat_d = div_lat_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      f_pop     = 1'b0;
      case (state_q)
         UART_IDLE: begin
            tx_d = 1'b1;
            if (!f_empty) begin
               f_pop     = 1'b1;
               shift_d   = f_dout;
               div_lat_d = div_eff;
               cnt_d     = div_eff - 16'd1;
               tx_d      = 1'b0;
               state_d   = UART_START;
            end
         end
         UART_START: begin
            if (cnt_q == '0) begin
               state_d = UART_DATA;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
               cnt_d   = div_lat_q - 16'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         UART_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = div_lat_q - 16'd1;
               if (bit_q == 3'd7) begin
                  state_d = UART_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         UART_STOP: begin
            if (cnt_q == '0) begin
               state_d = UART_IDLE;
               tx_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = UART_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_comb begin
      div_d = div_q;
      ovf_d = ovf_q;
      if (wr_div && byteena[0]) div_d[7:0]  = data[7:0];
      if (wr_div && byteena[1]) div_d[15:8] = data[15:8];
      // A new overflow wins over a same-cycle software clear.
      if (clr_ovf)   ovf_d = 1'b0;
      if (push_drop) ovf_d = 1'b1;

      q_d   = '0;
      sel_d = in_win;
      if (in_win) begin
         case (reg_idx)
            UART_REG_STATUS: q_d = uart_status_word(f_full, f_empty,
                                                    state_q != UART_IDLE,
                                                    ovf_q, cnt9[7:0]);
            UART_REG_DIV:    q_d = {16'h0000, div_q};
            default:         q_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= UART_IDLE;
         bit_q     <= '0;
         cnt_q     <= '0;
         div_lat_q <= 16'd1;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         div_q     <= DIV_RESET;
         ovf_q     <= 1'b0;
         q_q       <= '0;
         sel_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         div_lat_q <= div_lat_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         div_q     <= div_d;
         ovf_q     <= ovf_d;
         q_q       <= q_d;
         sel_q     <= sel_d;
      end
   end

   assign q         = q_q;
   assign sel       = sel_q;
   assign tx        = tx_q;
   assign irq_empty = f_empty & (state_q == UART_IDLE);

endmodule
